// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl: background scrubber that reads each word, runs it through an external SEC corrector and writes fixes back.
// Optional macro SCRUB_LOG_EN adds a sticky log of the most recent error (err_addr/err_uncorr/err_valid/err_clr).
module ecc_scrub_ctrl #(
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int CW       = 8,
  parameter int INTERVAL = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             mem_req,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW+CW-1:0] mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [DW+CW-1:0] mem_rdata,
  output logic [DW+CW-1:0] dec_din,
  input  logic [DW+CW-1:0] dec_dout,
  input  logic             dec_uncorr,
  output logic [15:0]      corr_cnt,
  output logic [15:0]      uncorr_cnt,
  output logic             pass_done,
  output logic             busy
`ifdef SCRUB_LOG_EN
  ,
  output logic [AW-1:0]    err_addr,
  output logic             err_uncorr,
  output logic             err_valid,
  input  logic             err_clr
`endif
);
  localparam int IW = INTERVAL > 1 ? $clog2(INTERVAL) : 1;
  typedef enum logic [2:0] {IDLE, RD, WAIT, CHK, WR, NEXT} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] ival_q, ival_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW+CW-1:0] raw_q, raw_d, wdata_q, wdata_d;
  logic [15:0] corr_q, corr_d, uncorr_q, uncorr_d;
  logic req_q, req_d, we_q, we_d, pass_q, pass_d;
  always_comb begin
    state_d  = state_q;
    ival_d   = ival_q;
    addr_d   = addr_q;
    raw_d    = raw_q;
    wdata_d  = wdata_q;
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    case (state_q)
      IDLE: if (en) begin
        ival_d  = ival_q == IW'(INTERVAL - 1) ? '0 : ival_q + 1'b1;
        state_d = ival_q == IW'(INTERVAL - 1) ? RD : IDLE;
      end
      RD:   state_d = mem_gnt ? WAIT : RD;
      WAIT: if (mem_rvalid) begin
        raw_d   = mem_rdata;
        state_d = CHK;
      end
      CHK: if (dec_uncorr) begin
        uncorr_d = uncorr_q + 16'(uncorr_q != 16'hFFFF);
        state_d  = NEXT;
      end else if (dec_dout != raw_q) begin
        corr_d  = corr_q + 16'(corr_q != 16'hFFFF);
        wdata_d = dec_dout;
        state_d = WR;
      end else begin
        state_d = NEXT;
      end
      WR:   state_d = mem_gnt ? NEXT : WR;
      NEXT: begin
        addr_d  = addr_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // Request/strobe flags are registered from the next state so the bus sees them on entry.
  assign req_d  = state_d == RD || state_d == WR;
  assign we_d   = state_d == WR;
  assign pass_d = state_d == NEXT && &addr_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ival_q   <= '0;
      addr_q   <= '0;
      raw_q    <= '0;
      wdata_q  <= '0;
      corr_q   <= '0;
      uncorr_q <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ival_q   <= ival_d;
      addr_q   <= addr_d;
      raw_q    <= raw_d;
      wdata_q  <= wdata_d;
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
      req_q    <= req_d;
      we_q     <= we_d;
      pass_q   <= pass_d;
    end
  end
  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign dec_din    = raw_q;
  assign corr_cnt   = corr_q;
  assign uncorr_cnt = uncorr_q;
  assign pass_done  = pass_q;
  assign busy       = state_q != IDLE;
`ifdef SCRUB_LOG_EN
  logic [AW-1:0] eaddr_q;
  logic etype_q, evalid_q, err_hit;
  // A new error in CHK takes priority over a coincident clear.
  assign err_hit = state_q == CHK && (dec_uncorr || dec_dout != raw_q);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eaddr_q  <= '0;
      etype_q  <= 1'b0;
      evalid_q <= 1'b0;
    end else if (err_hit) begin
      eaddr_q  <= addr_q;
      etype_q  <= dec_uncorr;
      evalid_q <= 1'b1;
    end else if (err_clr) begin
      evalid_q <= 1'b0;
    end
  end
  assign err_addr   = eaddr_q;
  assign err_uncorr = etype_q;
  assign err_valid  = evalid_q;
`endif
endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// tb_ecc_scrub_ctrl: drives a behavioural memory/arbiter and SEC corrector, predicts each scrub step from the stored words.
module tb_ecc_scrub_ctrl;
  localparam int AW = 2, DW = 32, CW = 8, N = DW + CW, INTERVAL = 2, WORDS = 4;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, mem_gnt = 1'b0, mem_rvalid = 1'b0, dec_uncorr;
  logic [N-1:0] mem_rdata = '0, dec_dout, mem_wdata, dec_din;
  logic mem_req, mem_we, pass_done, busy;
  logic [AW-1:0] mem_addr;
  logic [15:0] corr_cnt, uncorr_cnt;
`ifdef SCRUB_LOG_EN
  logic [AW-1:0] err_addr, m_eaddr;
  logic err_uncorr, err_valid, err_clr = 1'b0, m_etype, m_evalid;
  int clr_at = 0;
`endif
  int tests = 0, fails = 0;
  logic [N-1:0] golden[WORDS], mem[WORDS];
  int gnt_wait = 0, rv_delay = 0, wctr = 0, rv_cnt = 0;
  bit inject_rv = 0, rv_pend = 0, hs_req = 0, hs_we = 0;
  logic [AW-1:0] hs_addr, rv_addr, m_addr;
  logic [N-1:0] hs_wdata;
  logic [15:0] m_corr, m_uncorr;
  logic [AW-1:0] rd_q[$], wa_q[$];
  logic [N-1:0] wd_q[$];

  ecc_scrub_ctrl #(.AW(AW), .DW(DW), .CW(CW), .INTERVAL(INTERVAL)) dut (
    .clk(clk), .rst(rst), .en(en), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .dec_din(dec_din), .dec_dout(dec_dout), .dec_uncorr(dec_uncorr), .corr_cnt(corr_cnt),
    .uncorr_cnt(uncorr_cnt), .pass_done(pass_done), .busy(busy)
`ifdef SCRUB_LOG_EN
    , .err_addr(err_addr), .err_uncorr(err_uncorr), .err_valid(err_valid), .err_clr(err_clr)
`endif
  );

  always #5 clk = ~clk;

  // Corrector: any word within one bit of a known-good codeword maps back to it.
  always_comb begin
    dec_dout   = dec_din;
    dec_uncorr = 1'b1;
    for (int k = 0; k < WORDS; k++)
      if ($countones(dec_din ^ golden[k]) <= 1) begin
        dec_dout   = golden[k];
        dec_uncorr = 1'b0;
      end
  end

  // Memory + arbiter: decide grant at negedge, record the handshake at the following negedge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      mem_gnt = 0; mem_rvalid = 0; rv_pend = 0; wctr = 0; hs_req = 0;
    end else begin
      if (mem_gnt && hs_req) begin
        wctr = 0;
        if (hs_we) begin
          mem[hs_addr] = hs_wdata; wa_q.push_back(hs_addr); wd_q.push_back(hs_wdata);
        end else begin
          rd_q.push_back(hs_addr); rv_pend = 1; rv_cnt = rv_delay; rv_addr = hs_addr;
        end
      end
      mem_rvalid = 0;
      if (inject_rv) begin
        mem_rvalid = 1; mem_rdata = ~mem[0]; inject_rv = 0;
      end else if (rv_pend) begin
        if (rv_cnt == 0) begin
          mem_rvalid = 1; mem_rdata = mem[rv_addr]; rv_pend = 0;
        end else rv_cnt--;
      end
      {hs_req, hs_we, hs_addr, hs_wdata} = {mem_req, mem_we, mem_addr, mem_wdata};
      if (mem_req && wctr >= gnt_wait) mem_gnt = 1;
      else begin
        mem_gnt = 0;
        if (mem_req) wctr++;
      end
    end
  end

  function automatic int kind(input logic [N-1:0] w, input logic [N-1:0] g);
    int c = $countones(w ^ g);
    return c > 1 ? 2 : c;
  endfunction

  function automatic logic [N-1:0] flip(input int nbits);
    logic [N-1:0] m = '0;
    int b = $urandom_range(0, N - 1);
    if (nbits > 0) m[b] = 1'b1;
    if (nbits > 1) m[(b + 1 + $urandom_range(0, N - 2)) % N] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    m_addr = '0; m_corr = '0; m_uncorr = '0;
`ifdef SCRUB_LOG_EN
    m_eaddr = '0; m_etype = 0; m_evalid = 0;
`endif
  endtask

  // Observes one step starting in a fresh IDLE cycle; samples 2 time units after each rising edge.
  task automatic run_step(output int idle, output int bc, output int pd, output int uns, output int to);
    logic [AW-1:0] pa;
    logic [N-1:0] pw;
    logic pwe, preq;
    idle = 0; bc = 0; pd = 0; uns = 0; to = 0; preq = 0; pa = '0; pw = '0; pwe = 0;
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    while (!busy) begin
      idle++;
      if (idle > 500) begin to = 1; return; end
      @(posedge clk); #2;
    end
    while (busy) begin
      bc++;
      if (pass_done) pd++;
      if (preq && mem_req && {pa, pwe, pw} !== {mem_addr, mem_we, mem_wdata}) uns++;
      {preq, pa, pwe, pw} = {mem_req, mem_addr, mem_we, mem_wdata};
`ifdef SCRUB_LOG_EN
      err_clr = clr_at != 0 && bc == clr_at;
`endif
      if (bc > 500) begin to = 1; return; end
      @(posedge clk); #2;
    end
  endtask

  // Runs n steps; tmode 0 = immediate bus, 1 = random waits, 2 = 10-cycle grant stall.
  task automatic test_scrub_steps(input string tag, input int n, input int tmode);
    for (int s = 0; s < n; s++) begin
      int idle, bc, pd, uns, to, g, d, k, exp_bc;
      logic [AW-1:0] a;
      logic [N-1:0] w;
      g = tmode == 1 ? $urandom_range(0, 4) : tmode == 2 ? 10 : 0;
      d = tmode == 1 ? $urandom_range(0, 4) : 0;
      gnt_wait = g; rv_delay = d;
      a = m_addr; w = mem[a]; k = kind(w, golden[a]);
      exp_bc = 4 + g + d + (k == 1 ? 1 + g : 0);
      run_step(idle, bc, pd, uns, to);
      if (k == 1 && m_corr != 16'hFFFF) m_corr++;
      if (k == 2 && m_uncorr != 16'hFFFF) m_uncorr++;
      m_addr = m_addr + 1'b1;
      tests++; if (to != 0) begin fails++; $display("FAIL %s[%0d] timeout: busy=%0b idle=%0d bc=%0d", tag, s, busy, idle, bc); end
      tests++; if (idle != INTERVAL) begin fails++; $display("FAIL %s[%0d] idle: got %0d want %0d", tag, s, idle, INTERVAL); end
      tests++; if (bc != exp_bc) begin fails++; $display("FAIL %s[%0d] busy_cycles: got %0d want %0d", tag, s, bc, exp_bc); end
      tests++; if (rd_q.size() != 1 || rd_q[0] !== a) begin fails++; $display("FAIL %s[%0d] read: got %0d reads want 1 at %0d", tag, s, rd_q.size(), a); end
      tests++;
      if (wa_q.size() != (k == 1 ? 1 : 0) || (k == 1 && (wa_q[0] !== a || wd_q[0] !== golden[a]))) begin
        fails++; $display("FAIL %s[%0d] write: got %0d writes want %0d (addr %0d data %h)", tag, s, wa_q.size(), k == 1, a, golden[a]);
      end
      tests++; if (pd != (a == WORDS - 1 ? 1 : 0)) begin fails++; $display("FAIL %s[%0d] pass_done: got %0d pulses want %0d", tag, s, pd, a == WORDS - 1); end
      tests++; if (uns != 0) begin fails++; $display("FAIL %s[%0d] req_stable: got %0d changes want 0", tag, s, uns); end
      tests++; if (dec_din !== w) begin fails++; $display("FAIL %s[%0d] dec_din: got %h want %h", tag, s, dec_din, w); end
      tests++;
      if ({corr_cnt, uncorr_cnt, mem_addr} !== {m_corr, m_uncorr, m_addr}) begin
        fails++; $display("FAIL %s[%0d] counters/addr: got %h/%h/%0d want %h/%h/%0d", tag, s, corr_cnt, uncorr_cnt, mem_addr, m_corr, m_uncorr, m_addr);
      end
`ifdef SCRUB_LOG_EN
      if (k != 0) begin m_evalid = 1; m_eaddr = a; m_etype = k == 2; end
      else if (clr_at != 0) m_evalid = 0;
      tests++;
      if ({err_valid, err_uncorr, err_addr} !== {m_evalid, m_etype, m_eaddr}) begin
        fails++; $display("FAIL %s[%0d] err_log: got v%0b u%0b a%0d want v%0b u%0b a%0d", tag, s, err_valid, err_uncorr, err_addr, m_evalid, m_etype, m_eaddr);
      end
`endif
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #2;
    tests++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, dec_din, corr_cnt, uncorr_cnt, pass_done, busy} !== '0) begin
      fails++; $display("FAIL reset outputs: req%0b we%0b addr%0d wd%h din%h c%h u%h pd%0b busy%0b want all 0",
                        mem_req, mem_we, mem_addr, mem_wdata, dec_din, corr_cnt, uncorr_cnt, pass_done, busy);
    end
    @(negedge clk); #1;
    rst = 0; en = 1;
    model_reset();
  endtask

  task automatic test_clean_pass();
    test_scrub_steps("clean", 4, 0);
  endtask

  task automatic test_single_bit();
    logic [N-1:0] m = '0;
    m[5] = 1'b1;
    mem[1] = golden[1] ^ m;
    test_scrub_steps("sbe", 8, 0);
    tests++; if (mem[1] !== golden[1]) begin fails++; $display("FAIL sbe mem1: got %h want %h", mem[1], golden[1]); end
  endtask

  task automatic test_uncorrectable();
    logic [N-1:0] m = '0;
    m[7] = 1'b1; m[20] = 1'b1;
    mem[2] = golden[2] ^ m;
    test_scrub_steps("uncorr", 4, 0);
    tests++; if (mem[2] !== (golden[2] ^ m)) begin fails++; $display("FAIL uncorr mem2 rewritten: got %h want %h", mem[2], golden[2] ^ m); end
    mem[2] = golden[2];
  endtask

  task automatic test_enable();
    int idle, bc, pd, uns, to, bad = 0;
    @(posedge clk); #2;
    en = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      if (busy || mem_req) bad++;
    end
    en = 1;
    gnt_wait = 0; rv_delay = 0;
    run_step(idle, bc, pd, uns, to);
    m_addr = m_addr + 1'b1;
    tests++; if (bad != 0) begin fails++; $display("FAIL en_hold activity: got %0d active cycles want 0", bad); end
    tests++; if (idle != 1 || to != 0) begin fails++; $display("FAIL en_hold frozen_counter: got idle %0d want 1", idle); end
    tests++; if (bc != 4 || mem_addr !== m_addr) begin fails++; $display("FAIL en_hold step: got bc %0d addr %0d want 4 %0d", bc, mem_addr, m_addr); end
  endtask

  task automatic test_arbiter_stall();
    mem[m_addr] = golden[m_addr] ^ flip(1);
    test_scrub_steps("stall", 1, 2);
    mem[m_addr] = golden[m_addr];
    test_scrub_steps("stall_rd", 1, 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      mem[m_addr] = golden[m_addr] ^ flip($urandom_range(0, 2));
      test_scrub_steps("rand", 1, 1);
    end
  endtask

  task automatic test_saturation();
    force dut.corr_q = 16'hFFFD;
    #1;
    release dut.corr_q;
    m_corr = 16'hFFFD;
    for (int i = 0; i < 3; i++) begin
      mem[m_addr] = golden[m_addr] ^ flip(1);
      test_scrub_steps("sat", 1, 0);
    end
    tests++; if (corr_cnt !== 16'hFFFF) begin fails++; $display("FAIL sat hold: got %h want ffff", corr_cnt); end
  endtask

`ifdef SCRUB_LOG_EN
  task automatic test_err_log();
    mem[m_addr] = golden[m_addr];
    clr_at = 1;
    test_scrub_steps("log_clr", 1, 0);
    mem[m_addr] = golden[m_addr] ^ flip(1);
    clr_at = 3;
    test_scrub_steps("log_win", 1, 0);
    clr_at = 0;
  endtask
`endif

  task automatic test_reset_mid();
    gnt_wait = 0; rv_delay = 6;
    rd_q.delete();
    for (int i = 0; i < 20 && rd_q.size() == 0; i++) begin @(posedge clk); #2; end
    tests++; if (rd_q.size() == 0) begin fails++; $display("FAIL rst_mid reach_wait: got 0 reads want 1"); end
    rst = 1;
    #1;
    tests++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, dec_din, corr_cnt, uncorr_cnt, pass_done, busy} !== '0) begin
      fails++; $display("FAIL rst_mid outputs: req%0b addr%0d din%h c%h u%h busy%0b want all 0", mem_req, mem_addr, dec_din, corr_cnt, uncorr_cnt, busy);
    end
    @(negedge clk); #1;
    rst = 0; rv_delay = 0; inject_rv = 1;
    model_reset();
    test_scrub_steps("post_rst", 4, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < WORDS; k++) begin
      golden[k] = N'({$urandom(), $urandom()});
      mem[k] = golden[k];
    end
    test_reset();
    test_clean_pass();
    test_single_bit();
    test_uncorrectable();
    test_enable();
    test_arbiter_stall();
    test_random();
    test_saturation();
`ifdef SCRUB_LOG_EN
    test_err_log();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
